// File: rtl/div_ctrl.sv
// Restoring unsigned 16/16 divider controller: one quotient bit per clock,
// with the subtract itself done by an external stage fed through rest_a/rest_b.
module div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        en_rest,
  output logic        zero,
  output logic [3:0]  count,
  output logic [3:0]  bits,
  output logic [15:0] rest_a,
  output logic [15:0] rest_b,
  input  logic [15:0] rest_in
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [3:0] msb_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] dvd_q, dvd_d;
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] r_q, r_d;
  logic [15:0] qwork_q, qwork_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  bits_q, bits_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [16:0] s_s;
  logic        zero_s;
  logic        in_iter_s;
  logic [3:0]  qidx_s;

  // Shifted partial remainder and the 17-bit no-subtract decision
  always_comb begin
    in_iter_s = (state_q == ST_ITER);
    qidx_s    = 4'd15 - cnt_q;
    s_s       = {r_q, dvd_q[qidx_s]};
    if (in_iter_s) begin
      zero_s = (s_s < {1'b0, dvs_q});
    end else begin
      zero_s = 1'b0;
    end
  end

  // Datapath handshake toward the subtract stage; quiet outside ITER
  always_comb begin
    busy        = in_iter_s;
    done        = (state_q == ST_DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    zero        = zero_s;
    if (in_iter_s) begin
      en_rest = 1'b1;
      rest_a  = s_s[15:0];
      rest_b  = dvs_q;
      count   = cnt_q;
      bits    = bits_q;
    end else begin
      en_rest = 1'b0;
      rest_a  = 16'h0000;
      rest_b  = 16'h0000;
      count   = 4'd0;
      bits    = 4'd0;
    end
  end

  // FSM next-state and register updates
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    qwork_d = qwork_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != 16'h0000) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            r_d     = 16'h0000;
            qwork_d = 16'h0000;
            cnt_d   = 4'd0;
            bits_d  = msb_index(divisor);
            state_d = ST_ITER;
          end else begin
            quot_d  = 16'hFFFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        r_d             = rest_in;
        qwork_d[qidx_s] = ~zero_s;
        if (cnt_q == 4'd15) begin
          // Results publish only here, so outputs stay stable during the next run
          quot_d  = qwork_d;
          rem_d   = rest_in;
          dbz_d   = 1'b0;
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ST_ITER;
        end
      end
      ST_DONE: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dvd_q   <= 16'h0000;
      dvs_q   <= 16'h0000;
      r_q     <= 16'h0000;
      qwork_q <= 16'h0000;
      cnt_q   <= 4'd0;
      bits_q  <= 4'd0;
      quot_q  <= 16'h0000;
      rem_q   <= 16'h0000;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      qwork_q <= qwork_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected results, a negedge
// monitor pops and compares whenever done is presented.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'h0000;
  logic [15:0] divisor = 16'h0000;
  logic        busy, done, div_by_zero, en_rest, zero;
  logic [15:0] quotient, remainder, rest_a, rest_b, rest_in;
  logic [3:0]  count, bits;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .en_rest(en_rest), .zero(zero), .count(count),
    .bits(bits), .rest_a(rest_a), .rest_b(rest_b), .rest_in(rest_in)
  );

  always #5 clk = ~clk;

  // subtract-stage model
  assign rest_in = en_rest ? (zero ? rest_a : rest_a - rest_b) : rest_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(mon_e.q));
        check("remainder", 64'(remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Drives start for one cycle; returns 1ns into cycle k+1 (k = accepting edge)
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic dbz);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    e.q = q; e.r = r; e.dbz = dbz; e.cyc = cyc + 1 + (dbz ? 0 : 16);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic check_quiet(input string name);
    check(name, 64'({busy, done, en_rest, zero, count, bits}), 64'd0);
    check({name, "_rest"}, 64'({rest_a, rest_b}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    #12;
    check_quiet("reset_ctl");
    check("reset_results", 64'({quotient, remainder, div_by_zero}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 100 / 7
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    check("s1_busy_k1", 64'(busy), 64'd1);
    check("s1_count_k1", 64'(count), 64'd0);
    check("s1_bits", 64'(bits), 64'd2);
    repeat (15) @(posedge clk);
    #1;
    check("s1_count_k16", 64'(count), 64'd15);
    check("s1_busy_k16", 64'({busy, done}), 64'b10);
    wait_done();
    check_quiet("s1_idle");
    check("s1_quot_held", 64'(quotient), 64'd14);

    // FFFF / 1
    issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    check("s2_bits", 64'(bits), 64'd0);
    wait_done();

    // FFFF / 8001 needs the 17-bit compare
    issue(16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0);
    check("s3_bits", 64'(bits), 64'd15);
    wait_done();

    // 5 / 0
    issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    check("s4_busy", 64'(busy), 64'd0);
    wait_done();
    check("s4_busy_after", 64'(busy), 64'd0);

    // 1234 / FFFF with an ignored second start at k+5
    issue(16'h1234, 16'hFFFF, 16'h0000, 16'h1234, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'h0001; divisor = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
    wait_done();
    check("s5_idle_busy", 64'(busy), 64'd0);

    // reset pulsed mid-division
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_quiet("s6_reset_ctl");
    check("s6_reset_results", 64'({quotient, remainder, div_by_zero}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("s6_reset_hold", 64'({busy, done, quotient}), 64'd0);
    // release reset together with start: accepted on the next edge
    rst_n = 1'b1; start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    e.q = 16'd14; e.r = 16'd2; e.dbz = 1'b0; e.cyc = cyc + 17;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
    check("s6_busy_k1", 64'(busy), 64'd1);
    wait_done();
    check_quiet("s6_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
